maxpool_loader: RTL and testbench

MAXPOOL_LOADER -- requirements
Module: maxpool_loader

---
 rtl/maxpool_loader.sv | 156 +++++++++++++++
 tb/tb_maxpool_loader.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_loader.sv
// Gathers 2x12 int16 windows from memory as six 8-byte beats and presents each
// packed window with its source and destination addresses to a 2x2 max-pool stage.
module maxpool_loader #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [63:0]      in_base,
    input  logic [63:0]      out_base,
    input  logic [63:0]      row_stride,
    input  logic [CNT_W-1:0] num_windows,
    output logic             busy,
    output logic             done,
    output logic             mem_ren,
    output logic [63:0]      mem_raddr,
    input  logic             mem_rvalid,
    input  logic [63:0]      mem_rdata,
    output logic             pool_valid,
    input  logic             pool_ready,
    output logic [383:0]     pool_rdata,
    output logic [63:0]      pool_raddr,
    output logic [63:0]      pool_waddr
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        OUT,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] K_ONE      = CNT_W'(1);
    localparam logic [2:0]       LAST_BEAT  = 3'd5;
    localparam logic [63:0]      RESULT_BYTES = 64'd12;

    state_t             state;
    state_t             state_nxt;
    logic [63:0]        stride_q;
    logic [CNT_W-1:0]   num_q;
    logic [CNT_W-1:0]   k;
    logic [CNT_W-1:0]   k_inc;
    logic [2:0]         b;
    // The latched in_base/out_base live on as the starting values of these
    // accumulators, which step by one window per accept.
    logic [63:0]        rowbase;
    logic [63:0]        waddr_acc;
    logic [383:0]       rdata_q;
    logic [63:0]        row_off;
    logic [63:0]        col_off;
    logic [63:0]        beat_addr;

    assign k_inc = k + K_ONE;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (num_windows == '0) ? DONE : REQ;
                end
            end
            REQ:  state_nxt = WAIT;
            WAIT: begin
                if (mem_rvalid) begin
                    state_nxt = (b == LAST_BEAT) ? OUT : REQ;
                end
            end
            OUT: begin
                if (pool_ready) begin
                    state_nxt = (k_inc == num_q) ? DONE : REQ;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Beats 0..2 cover row 0 and beats 3..5 cover row 1; offsets are picked,
    // not multiplied.
    always_comb begin
        col_off = 64'd0;
        row_off = 64'd0;
        case (b)
            3'd1, 3'd4: col_off = 64'd8;
            3'd2, 3'd5: col_off = 64'd16;
            default:    col_off = 64'd0;
        endcase
        if (b >= 3'd3) begin
            row_off = stride_q;
        end
    end

    assign beat_addr = rowbase + row_off + col_off;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            stride_q  <= '0;
            num_q     <= '0;
            k         <= '0;
            b         <= '0;
            rowbase   <= '0;
            waddr_acc <= '0;
            // NOTE: the window buffer is a plain register bank, not a RAM, so
            // clearing it on reset costs nothing and keeps the outputs defined.
            rdata_q   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        rowbase   <= in_base;
                        waddr_acc <= out_base;
                        stride_q  <= row_stride;
                        num_q     <= num_windows;
                        k         <= '0;
                        b         <= '0;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        rdata_q[{b, 6'd0} +: 64] <= mem_rdata;
                        if (b != LAST_BEAT) begin
                            b <= b + 3'd1;
                        end
                    end
                end
                OUT: begin
                    if (pool_ready) begin
                        k         <= k_inc;
                        b         <= '0;
                        rowbase   <= rowbase + {stride_q[62:0], 1'b0};
                        waddr_acc <= waddr_acc + RESULT_BYTES;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign mem_ren    = (state == REQ);
    assign mem_raddr  = (state == REQ) ? beat_addr : 64'd0;
    assign pool_valid = (state == OUT);
    assign pool_rdata = rdata_q;
    assign pool_raddr = rowbase;
    assign pool_waddr = waddr_acc;

endmodule

// File: tb/tb_maxpool_loader.sv
// Directed bench for maxpool_loader: a small memory responder with selectable
// latency and spurious returns, and hand-computed window addresses.
module tb_maxpool_loader;

    localparam int CNT_W = 16;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [63:0]      in_base;
    logic [63:0]      out_base;
    logic [63:0]      row_stride;
    logic [CNT_W-1:0] num_windows;
    logic             busy;
    logic             done;
    logic             mem_ren;
    logic [63:0]      mem_raddr;
    logic             mem_rvalid;
    logic [63:0]      mem_rdata;
    logic             pool_valid;
    logic             pool_ready;
    logic [383:0]     pool_rdata;
    logic [63:0]      pool_raddr;
    logic [63:0]      pool_waddr;

    int vectors     = 0;
    int miscompares = 0;

    logic        tb_rvalid;
    logic [63:0] tb_rdata;
    logic        rsp_rvalid;
    logic [63:0] rsp_rdata;
    logic [63:0] rsp_addr;
    int          rsp_lat;
    int          lat_mode;
    bit          spur_en;
    int          beat_cnt;
    logic [63:0] addr_log[$];

    assign mem_rvalid = tb_rvalid | rsp_rvalid;
    assign mem_rdata  = rsp_rvalid ? rsp_rdata : tb_rdata;

    maxpool_loader #(.CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .in_base    (in_base),
        .out_base   (out_base),
        .row_stride (row_stride),
        .num_windows(num_windows),
        .busy       (busy),
        .done       (done),
        .mem_ren    (mem_ren),
        .mem_raddr  (mem_raddr),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .pool_valid (pool_valid),
        .pool_ready (pool_ready),
        .pool_rdata (pool_rdata),
        .pool_raddr (pool_raddr),
        .pool_waddr (pool_waddr)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] beat_data(input logic [63:0] a);
        return {a[15:0] + 16'd3, a[15:0] + 16'd2, a[15:0] + 16'd1, a[15:0]};
    endfunction

    function automatic logic [383:0] pack6(input logic [63:0] a0, input logic [63:0] a1,
                                           input logic [63:0] a2, input logic [63:0] a3,
                                           input logic [63:0] a4, input logic [63:0] a5);
        return {beat_data(a5), beat_data(a4), beat_data(a3),
                beat_data(a2), beat_data(a1), beat_data(a0)};
    endfunction

    task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check(tag, 384'(obs), 384'(exp));
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic launch(input logic [63:0] ib, input logic [63:0] ob,
                          input logic [63:0] rs, input logic [CNT_W-1:0] nw);
        in_base     = ib;
        out_base    = ob;
        row_stride  = rs;
        num_windows = nw;
        start       = 1'b1;
        step();
        start       = 1'b0;
        in_base     = 64'hDEAD_0000_0000_0100;
        out_base    = 64'hDEAD_0000_0000_0200;
        row_stride  = 64'h0000_0000_0000_0007;
        num_windows = CNT_W'(9);
    endtask

    task automatic wait_valid(input string tag, output int cyc);
        cyc = 0;
        while (pool_valid !== 1'b1 && cyc < 400) begin
            step();
            cyc++;
        end
        chk({tag, "_valid"}, 64'(pool_valid), 64'd1);
    endtask

    task automatic accept();
        pool_ready = 1'b1;
        step();
        pool_ready = 1'b0;
    endtask

    task automatic check_window(input string tag, input int base,
                                input logic [63:0] raddr, input logic [63:0] waddr,
                                input logic [63:0] a0, input logic [63:0] a1,
                                input logic [63:0] a2, input logic [63:0] a3,
                                input logic [63:0] a4, input logic [63:0] a5);
        logic [63:0] e[6];
        e = '{a0, a1, a2, a3, a4, a5};
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("%s_rd%0d", tag, i), addr_log[base + i], e[i]);
        end
        check({tag, "_rdata"}, pool_rdata, pack6(a0, a1, a2, a3, a4, a5));
        chk({tag, "_raddr"}, pool_raddr, raddr);
        chk({tag, "_waddr"}, pool_waddr, waddr);
    endtask

    // Memory responder: one read outstanding, latency chosen by lat_mode,
    // optional junk rvalid during the REQ cycle and the wait cycles.
    initial begin
        rsp_rvalid = 1'b0;
        rsp_rdata  = 64'd0;
        beat_cnt   = 0;
        #1;
        forever begin
            if (mem_ren === 1'b1) begin
                rsp_addr = mem_raddr;
                addr_log.push_back(rsp_addr);
                rsp_lat  = (lat_mode == 0) ? 1 : (lat_mode == 2) ? 5 : 1 + (beat_cnt % 5);
                beat_cnt++;
                if (spur_en) begin
                    rsp_rvalid = 1'b1;
                    rsp_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
                end
                for (int i = 1; i <= rsp_lat; i++) begin
                    @(posedge clock);
                    #1;
                    rsp_rvalid = (i == rsp_lat);
                    rsp_rdata  = (i == rsp_lat) ? beat_data(rsp_addr) : 64'hBAD0_BAD0_BAD0_BAD0;
                end
                @(posedge clock);
                #1;
                rsp_rvalid = 1'b0;
            end else begin
                @(posedge clock);
                #1;
            end
        end
    end

    initial begin
        int cyc;
        int n0;
        int ren_seen;
        logic [383:0] w2_pack;

        reset       = 1'b1;
        start       = 1'b0;
        in_base     = 64'd0;
        out_base    = 64'd0;
        row_stride  = 64'd0;
        num_windows = '0;
        pool_ready  = 1'b0;
        tb_rvalid   = 1'b0;
        tb_rdata    = 64'd0;
        lat_mode    = 0;
        spur_en     = 1'b0;
        repeat (3) step();

        // Reset state
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ren", 64'(mem_ren), 64'd0);
        chk("rst_pvalid", 64'(pool_valid), 64'd0);
        chk("rst_mraddr", mem_raddr, 64'd0);
        chk("rst_praddr", pool_raddr, 64'd0);
        chk("rst_pwaddr", pool_waddr, 64'd0);
        check("rst_prdata", pool_rdata, 384'd0);
        reset = 1'b0;
        step();

        // Single window, single-cycle read return
        n0 = addr_log.size();
        launch(64'h1000, 64'h2000, 64'h18, CNT_W'(1));
        chk("t1_busy", 64'(busy), 64'd1);
        wait_valid("t1", cyc);
        chk("t1_latency", 64'(cyc), 64'd12);
        check_window("t1", n0, 64'h1000, 64'h2000,
                     64'h1000, 64'h1008, 64'h1010, 64'h1018, 64'h1020, 64'h1028);
        accept();
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_done_busy", 64'(busy), 64'd1);
        step();
        chk("t1_done_drop", 64'(done), 64'd0);
        chk("t1_idle", 64'(busy), 64'd0);

        // Three windows, backpressure on the first, ready held early on the last
        n0 = addr_log.size();
        launch(64'h1000, 64'h2000, 64'h40, CNT_W'(3));
        wait_valid("t2w0", cyc);
        check_window("t2w0", n0, 64'h1000, 64'h2000,
                     64'h1000, 64'h1008, 64'h1010, 64'h1040, 64'h1048, 64'h1050);
        ren_seen = 0;
        for (int i = 0; i < 10; i++) begin
            start   = (i == 3);
            in_base = 64'h9000;
            step();
            if (mem_ren === 1'b1) ren_seen++;
            chk("t2_bp_valid", 64'(pool_valid), 64'd1);
            check("t2_bp_rdata", pool_rdata,
                  pack6(64'h1000, 64'h1008, 64'h1010, 64'h1040, 64'h1048, 64'h1050));
            chk("t2_bp_raddr", pool_raddr, 64'h1000);
            chk("t2_bp_waddr", pool_waddr, 64'h2000);
        end
        start = 1'b0;
        chk("t2_bp_no_ren", 64'(ren_seen), 64'd0);
        accept();
        chk("t2_mid_busy", 64'(busy), 64'd1);
        chk("t2_mid_done", 64'(done), 64'd0);
        wait_valid("t2w1", cyc);
        check_window("t2w1", n0 + 6, 64'h1080, 64'h200C,
                     64'h1080, 64'h1088, 64'h1090, 64'h10C0, 64'h10C8, 64'h10D0);
        accept();
        pool_ready = 1'b1;
        wait_valid("t2w2", cyc);
        check_window("t2w2", n0 + 12, 64'h1100, 64'h2018,
                     64'h1100, 64'h1108, 64'h1110, 64'h1140, 64'h1148, 64'h1150);
        step();
        pool_ready = 1'b0;
        chk("t2_done", 64'(done), 64'd1);
        step();
        chk("t2_idle", 64'(busy), 64'd0);
        chk("t2_nreads", 64'(addr_log.size() - n0), 64'd18);
        w2_pack = pack6(64'h1100, 64'h1108, 64'h1110, 64'h1140, 64'h1148, 64'h1150);

        // Spurious return in IDLE, then variable latency with junk in REQ/WAIT,
        // addresses wrapping through 2^64
        tb_rvalid = 1'b1;
        tb_rdata  = 64'hFACE_FACE_FACE_FACE;
        step();
        tb_rvalid = 1'b0;
        chk("t3_idle_spur_busy", 64'(busy), 64'd0);
        check("t3_idle_spur_rdata", pool_rdata, w2_pack);
        lat_mode = 1;
        spur_en  = 1'b1;
        n0 = addr_log.size();
        launch(64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 64'h10, CNT_W'(2));
        wait_valid("t3w0", cyc);
        check_window("t3w0", n0, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8,
                     64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h8, 64'h8, 64'h10, 64'h18);
        accept();
        wait_valid("t3w1", cyc);
        check_window("t3w1", n0 + 6, 64'h18, 64'h4,
                     64'h18, 64'h20, 64'h28, 64'h28, 64'h30, 64'h38);
        accept();
        chk("t3_done", 64'(done), 64'd1);
        step();
        lat_mode = 0;
        spur_en  = 1'b0;

        // Zero windows; start during the DONE cycle is ignored
        n0 = addr_log.size();
        in_base     = 64'h7000;
        out_base    = 64'h8000;
        row_stride  = 64'h10;
        num_windows = '0;
        start       = 1'b1;
        step();
        chk("t4_busy", 64'(busy), 64'd1);
        chk("t4_done", 64'(done), 64'd1);
        chk("t4_ren", 64'(mem_ren), 64'd0);
        step();
        start = 1'b0;
        chk("t4_idle_busy", 64'(busy), 64'd0);
        chk("t4_idle_done", 64'(done), 64'd0);
        step();
        chk("t4_still_idle", 64'(busy), 64'd0);
        chk("t4_nreads", 64'(addr_log.size() - n0), 64'd0);

        // Reset while waiting on beat 3; the late return must be dropped
        lat_mode = 2;
        launch(64'h3000, 64'h4000, 64'h100, CNT_W'(2));
        cyc = 0;
        while (!(mem_ren === 1'b1 && mem_raddr === 64'h3100) && cyc < 100) begin
            step();
            cyc++;
        end
        chk("t5_beat3_addr", mem_raddr, 64'h3100);
        step();
        chk("t5_wait_ren", 64'(mem_ren), 64'd0);
        reset = 1'b1;
        step();
        chk("t5_rst_busy", 64'(busy), 64'd0);
        chk("t5_rst_done", 64'(done), 64'd0);
        chk("t5_rst_ren", 64'(mem_ren), 64'd0);
        chk("t5_rst_pvalid", 64'(pool_valid), 64'd0);
        chk("t5_rst_mraddr", mem_raddr, 64'd0);
        chk("t5_rst_praddr", pool_raddr, 64'd0);
        chk("t5_rst_pwaddr", pool_waddr, 64'd0);
        check("t5_rst_prdata", pool_rdata, 384'd0);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t5_late_busy", 64'(busy), 64'd0);
            chk("t5_late_done", 64'(done), 64'd0);
        end
        check("t5_late_rdata", pool_rdata, 384'd0);
        lat_mode = 0;
        n0 = addr_log.size();
        launch(64'h5000, 64'h6000, 64'h20, CNT_W'(1));
        wait_valid("t5", cyc);
        check_window("t5", n0, 64'h5000, 64'h6000,
                     64'h5000, 64'h5008, 64'h5010, 64'h5020, 64'h5028, 64'h5030);
        accept();
        chk("t5_done", 64'(done), 64'd1);
        step();
        chk("t5_done_drop", 64'(done), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
